// File: rtl/key_expander_seq.sv
// AES-128 key schedule: one round key per clock, all eleven keys packed on key_all.
// Latency: start accepted on E0, rk1..rk10 on E1..E10, done pulses the cycle after E10.
// Backpressure: none; start is ignored while busy and accepted again in IDLE or DONE.

// Byte substitution computed arithmetically: multiplicative inverse in GF(2^8), then affine map.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
      logic [7:0] p;
      logic [7:0] s;
      p = 8'h00;
      s = x;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) p = p ^ s;
         s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the cipher requires
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = gmul(x, x);
      for (int i = 1; i < 8; i++) begin
         r  = gmul(r, sq);
         sq = gmul(sq, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   assign y = affine(ginv(a));
endmodule

module key_expander_seq #(
   parameter int NR           = 10,
   parameter bit CLR_ON_START = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [127:0]            key_in,
   output logic                    busy,
   output logic                    done,
   output logic                    key_valid,
   output logic [3:0]              round_cnt,
   output logic [128*(NR+1)-1:0]   key_all
);
   typedef enum logic [1:0] {IDLE, EXPAND, FIN} state_t;

   state_t        state, state_nxt;
   logic          accept;
   logic          last;
   logic [7:0]    rcon;
   logic [127:0]  cur_key;
   logic [127:0]  nxt_key;
   logic [31:0]   rot_w3;
   logic [31:0]   sub_w;
   logic [31:0]   t_w;

   // previous round key kept separately so the round function never muxes key_all
   assign rot_w3 = {cur_key[23:0], cur_key[31:24]};

   aes_sbox u_sb3 (.a(rot_w3[31:24]), .y(sub_w[31:24]));
   aes_sbox u_sb2 (.a(rot_w3[23:16]), .y(sub_w[23:16]));
   aes_sbox u_sb1 (.a(rot_w3[15:8]),  .y(sub_w[15:8]));
   aes_sbox u_sb0 (.a(rot_w3[7:0]),   .y(sub_w[7:0]));

   assign t_w = sub_w ^ {rcon, 24'h000000};

   // chained word XORs of one full round, all within the cycle
   always_comb begin
      nxt_key[127:96] = cur_key[127:96] ^ t_w;
      nxt_key[95:64]  = cur_key[95:64]  ^ nxt_key[127:96];
      nxt_key[63:32]  = cur_key[63:32]  ^ nxt_key[95:64];
      nxt_key[31:0]   = cur_key[31:0]   ^ nxt_key[63:32];
   end

   // next-state and start acceptance; DONE accepts a start just like IDLE
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = EXPAND;
            end
         end
         EXPAND: begin
            if (round_cnt == 4'(NR)) begin
               last      = 1'b1;
               state_nxt = FIN;
            end
         end
         FIN: begin
            accept    = start;
            state_nxt = start ? EXPAND : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == EXPAND);
   assign done = (state == FIN);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // datapath: load rk0 on accept, then one round key per EXPAND edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         round_cnt <= 4'd0;
         rcon      <= 8'h01;
         key_valid <= 1'b0;
         cur_key   <= 128'h0;
         key_all   <= '0;
      end else if (accept) begin
         cur_key   <= key_in;
         round_cnt <= 4'd1;
         rcon      <= 8'h01;
         key_valid <= 1'b0;
         if (CLR_ON_START) key_all <= {key_in, {(128*NR){1'b0}}};
         else              key_all[128*(NR+1)-1 -: 128] <= key_in;
      end else if (state == EXPAND) begin
         cur_key <= nxt_key;
         for (int i = 1; i <= NR; i++) begin
            if (round_cnt == 4'(i)) key_all[(NR-i)*128 +: 128] <= nxt_key;
         end
         rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         round_cnt <= last ? 4'd0 : round_cnt + 4'd1;
         if (last) key_valid <= 1'b1;
      end
   end
endmodule
